csr_access_ctrl: RTL and testbench
==================================

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data width.
REQ-002 SHALL have parameter SRANDOM_WAIT, default 16, the maximum cycles to wait for entropy.
REQ-003 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have request ports: req_valid in 1; req_ready out 1; req_funct3 in 3; req_csr_addr in 12; req_rs1_val in XLEN; req_zimm in 5; req_rd in 5; req_pc in XLEN; cur_priv in priv_e.
REQ-005 SHALL have CSR-side ports: csr_en out 1; csr_funct3 out 3; csr_addr out 12; csr_wval out XLEN; csr_rval in XLEN; csr_illegal in 1; entropy_valid in 1.
REQ-006 SHALL have result ports: wb_valid out 1; wb_rd out 5; wb_data out XLEN; done out 1; kill_i in 1 (pipeline flush).
REQ-007 SHALL have trap ports: trap_req out 1; trap_cause out XLEN; trap_epc out XLEN; trap_tval out XLEN.

Function
REQ-008 SHALL implement the FSM states IDLE, ISSUE, RND_WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-009 SHALL register all req_* fields and cur_priv on the handshake (req_valid&&req_ready), then go to ISSUE.
REQ-010 SHALL compute operand = funct3[2] ? zero-extended zimm : rs1_val, and drive csr_wval = operand.
REQ-011 SHALL define a write attempt as funct3[1:0]==01, or funct3[1:0] in {10,11} with operand!=0.
REQ-012 SHALL pre-check in ISSUE: funct3[1:0]==00, csr_addr[9:8] greater than the privilege level, or csr_addr[11:10]==11 together with a write attempt SHALL each be illegal.
REQ-013 SHALL keep csr_en low on a pre-check failure and go to RESP with a trap pending.
REQ-014 SHALL, when csr_addr==CSR_SRANDOM and entropy_valid==0 in ISSUE, keep csr_en low and go to RND_WAIT.
REQ-015 SHALL, on a passed pre-check (and entropy valid if SRANDOM), assert csr_en for exactly one cycle with the registered funct3/addr/wval.
REQ-016 SHALL, in that csr_en cycle, sample csr_rval into wb_data and csr_illegal into the pending-trap flag.
REQ-017 SHALL, in RESP, pulse done for 1 cycle and then return to IDLE.
REQ-018 SHALL, in RESP without a trap, pulse wb_valid only when rd!=0; wb_rd = registered rd.
REQ-019 SHALL, in RESP with a trap, pulse trap_req with trap_cause=2 (illegal instruction), trap_epc=registered pc, trap_tval=zero-extended csr_addr, and wb_valid=0.
REQ-020 SHALL, on kill_i in ISSUE or RND_WAIT, go to IDLE next cycle with no csr_en, wb_valid, trap_req or done; kill_i in IDLE or RESP SHALL be ignored.
REQ-021 SHALL guarantee that csr_en, wb_valid, trap_req and done are never asserted in the same cycle as each other in any combination other than done with wb_valid or done with trap_req.
REQ-022 SHALL give a request-to-done latency of 3 cycles without entropy wait.

Reset
REQ-023 SHALL, on rst_n low, place the FSM in IDLE and drive all outputs to 0 except req_ready=1, at any point including mid-operation.
REQ-024 SHALL, after reset, issue no csr_en until a new handshake.

Configuration
REQ-025 SHALL, with CSR_SRANDOM_RETRY_EN defined, hold RND_WAIT up to SRANDOM_WAIT cycles and issue csr_en on the first cycle entropy_valid==1; at counter expiry it SHALL trap as in REQ-019 without csr_en.
REQ-026 SHALL, without CSR_SRANDOM_RETRY_EN, make RND_WAIT unreachable and trap an SRANDOM read with entropy_valid==0 immediately via RESP with no csr_en.

Structure
REQ-027 SHALL take priv_e, PRIV_U/S/M, CSR_* addresses and the illegal-instruction cause constant from the shared HarvOS package; no local redefinitions.
REQ-028 SHALL be a single module with no sub-modules; the wait counter SHALL be $clog2(SRANDOM_WAIT+1) bits wide.

Verification
REQ-029 SHALL cover: CSRRW to CSR_STVEC from S, rs1=0x8000_0103, rd=5 -> one csr_en cycle with wval=0x8000_0103; wb_valid with rd=5, data=old stvec; done at cycle 3.
REQ-030 SHALL cover: CSRRS to CSR_MSTATUS from S with rs1=0 -> no csr_en; trap_req with cause=2, tval=0x300.
REQ-031 SHALL cover: CSRRW to CSR_SCAPS from M -> no csr_en and trap; CSRRS to CSR_SCAPS with rs1=0, rd=3 -> wb_data=SCAPS value, no trap.
REQ-032 SHALL cover: CSRRS to CSR_SRANDOM with entropy_valid low for 5 cycles then high with data 0xA5A5_A5A5 -> (EN) wb_data=0xA5A5_A5A5; (no EN) trap and no csr_en.
REQ-033 SHALL cover: SRANDOM with entropy never valid and EN defined -> trap after exactly SRANDOM_WAIT wait cycles; kill_i mid-wait -> IDLE, no outputs.
REQ-034 SHALL cover: csr_illegal=1 returned for an unknown address 0x7C0 from M -> trap_req, wb_valid=0; rst_n asserted in ISSUE -> req_ready=1, csr_en=0.

Source files
------------

// File: rtl/csr_access_ctrl_pkg.sv
// HarvOS shared definitions used by the CSR access controller:
// privilege levels, CSR addresses, trap cause codes and the CSR
// access pre-check rule.
package csr_access_ctrl_pkg;

    // Privilege levels as encoded in csr_addr[9:8]
    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_SCAPS   = 12'hDC0;  // S-level, read-only
    localparam logic [11:0] CSR_SRANDOM = 12'hDC1;  // S-level, read-only entropy

    localparam int unsigned CAUSE_ILLEGAL_INSTR = 2;

    // Access is illegal for a reserved funct3, insufficient privilege,
    // or any write attempt to a read-only CSR.
    function automatic logic csr_precheck_fail(input logic [2:0]  funct3,
                                               input logic [11:0] addr,
                                               input priv_e       priv,
                                               input logic        operand_nz);
        logic write_attempt;
        write_attempt = (funct3[1:0] == 2'b01) ||
                        ((funct3[1:0] != 2'b00) && operand_nz);
        return (funct3[1:0] == 2'b00) ||
               (addr[9:8] > 2'(priv)) ||
               ((addr[11:10] == 2'b11) && write_attempt);
    endfunction

endpackage

// File: rtl/csr_access_ctrl.sv
// CSR access controller: accepts one CSR instruction at a time, pre-checks
// legality, issues a single-cycle CSR-file access, and reports either a
// writeback or an illegal-instruction trap.
// Optional feature macro: CSR_SRANDOM_RETRY_EN -- when defined, an SRANDOM
// read without entropy waits up to SRANDOM_WAIT cycles instead of trapping.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_*, cur_priv, req_ready      request handshake and payload
//   csr_en/funct3/addr/wval         CSR-file access strobe and payload
//   csr_rval, csr_illegal           CSR-file read data and rejection
//   entropy_valid                   SRANDOM entropy availability
//   wb_valid, wb_rd, wb_data, done  completion / writeback
//   kill_i                          pipeline flush
//   trap_req/cause/epc/tval         trap report
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned SRANDOM_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_csr_addr,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [4:0]      req_zimm,
    input  logic [4:0]      req_rd,
    input  logic [XLEN-1:0] req_pc,
    input  priv_e           cur_priv,
    output logic            csr_en,
    output logic [2:0]      csr_funct3,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wval,
    input  logic [XLEN-1:0] csr_rval,
    input  logic            csr_illegal,
    input  logic            entropy_valid,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    input  logic            kill_i,
    output logic            trap_req,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_tval
);

    localparam int unsigned CNT_W = $clog2(SRANDOM_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RND_WAIT,
        ST_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trap_pend_q, trap_pend_d;
    logic [2:0]        f3_q, f3_d;
    logic [11:0]       addr_q, addr_d;
    logic [XLEN-1:0]   wval_q, wval_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    priv_e             priv_q, priv_d;

    logic              req_ready_q, req_ready_d;
    logic              csr_en_q, csr_en_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              done_q, done_d;
    logic              trap_req_q, trap_req_d;
    logic [XLEN-1:0]   trap_cause_q, trap_cause_d;
    logic [XLEN-1:0]   trap_epc_q, trap_epc_d;
    logic [XLEN-1:0]   trap_tval_q, trap_tval_d;

    logic              pend_now;

    // Next-state, capture and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        trap_pend_d  = trap_pend_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wval_d       = wval_q;
        rd_d         = rd_q;
        pc_d         = pc_q;
        priv_d       = priv_q;
        csr_en_d     = 1'b0;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        done_d       = 1'b0;
        trap_req_d   = 1'b0;
        trap_cause_d = '0;
        trap_epc_d   = '0;
        trap_tval_d  = '0;
        pend_now     = trap_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    f3_d        = req_funct3;
                    addr_d      = req_csr_addr;
                    wval_d      = req_funct3[2] ? XLEN'(req_zimm) : req_rs1_val;
                    rd_d        = req_rd;
                    pc_d        = req_pc;
                    priv_d      = cur_priv;
                    trap_pend_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (kill_i) begin
                    state_d = ST_IDLE;
                end else if (csr_precheck_fail(f3_q, addr_q, priv_q, wval_q != '0)) begin
                    trap_pend_d = 1'b1;
                    state_d     = ST_RESP;
                end else if ((addr_q == CSR_SRANDOM) && !entropy_valid) begin
`ifdef CSR_SRANDOM_RETRY_EN
                    cnt_d       = '0;
                    state_d     = ST_RND_WAIT;
`else
                    trap_pend_d = 1'b1;
                    state_d     = ST_RESP;
`endif
                end else begin
                    csr_en_d = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RND_WAIT: begin
                // cnt_q holds the number of wait cycles already spent
                if (kill_i) begin
                    state_d = ST_IDLE;
                end else if (entropy_valid) begin
                    csr_en_d = 1'b1;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_W'(SRANDOM_WAIT - 1)) begin
                    trap_pend_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // csr_en is high during this state when the access was issued
                if (csr_en_q) begin
                    wb_data_d   = csr_rval;
                    trap_pend_d = csr_illegal;
                    pend_now    = csr_illegal;
                end
                wb_rd_d = rd_q;
                done_d  = 1'b1;
                if (pend_now) begin
                    trap_req_d   = 1'b1;
                    trap_cause_d = XLEN'(CAUSE_ILLEGAL_INSTR);
                    trap_epc_d   = pc_q;
                    trap_tval_d  = XLEN'(addr_q);
                end else begin
                    wb_valid_d = (rd_q != 5'd0);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            trap_pend_q  <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wval_q       <= '0;
            rd_q         <= '0;
            pc_q         <= '0;
            priv_q       <= PRIV_U;
            req_ready_q  <= 1'b1;
            csr_en_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            done_q       <= 1'b0;
            trap_req_q   <= 1'b0;
            trap_cause_q <= '0;
            trap_epc_q   <= '0;
            trap_tval_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trap_pend_q  <= trap_pend_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wval_q       <= wval_d;
            rd_q         <= rd_d;
            pc_q         <= pc_d;
            priv_q       <= priv_d;
            req_ready_q  <= req_ready_d;
            csr_en_q     <= csr_en_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            done_q       <= done_d;
            trap_req_q   <= trap_req_d;
            trap_cause_q <= trap_cause_d;
            trap_epc_q   <= trap_epc_d;
            trap_tval_q  <= trap_tval_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign csr_en     = csr_en_q;
    assign csr_funct3 = f3_q;
    assign csr_addr   = addr_q;
    assign csr_wval   = wval_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign done       = done_q;
    assign trap_req   = trap_req_q;
    assign trap_cause = trap_cause_q;
    assign trap_epc   = trap_epc_q;
    assign trap_tval  = trap_tval_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: directed scenarios plus randomized requests,
// checked by a scoreboard against a behavioural CSR-access model.
module tb_csr_access_ctrl;
    import csr_access_ctrl_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned W    = 6;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_csr_addr;
    logic [XLEN-1:0] req_rs1_val;
    logic [4:0]      req_zimm;
    logic [4:0]      req_rd;
    logic [XLEN-1:0] req_pc;
    priv_e           cur_priv;
    logic            csr_en;
    logic [2:0]      csr_funct3;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wval;
    logic [XLEN-1:0] csr_rval;
    logic            csr_illegal;
    logic            entropy_valid;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            done;
    logic            kill_i;
    logic            trap_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_epc;
    logic [XLEN-1:0] trap_tval;

    csr_access_ctrl #(.XLEN(XLEN), .SRANDOM_WAIT(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_csr_addr(req_csr_addr), .req_rs1_val(req_rs1_val), .req_zimm(req_zimm),
        .req_rd(req_rd), .req_pc(req_pc), .cur_priv(cur_priv),
        .csr_en(csr_en), .csr_funct3(csr_funct3), .csr_addr(csr_addr),
        .csr_wval(csr_wval), .csr_rval(csr_rval), .csr_illegal(csr_illegal),
        .entropy_valid(entropy_valid),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
        .kill_i(kill_i),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .trap_tval(trap_tval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- CSR file seen by the DUT ----------------
    logic [11:0] addrs [8] = '{CSR_SSTATUS, CSR_STVEC, CSR_MSTATUS, CSR_MTVEC,
                               CSR_SCAPS, CSR_SRANDOM, 12'h7C0, 12'h040};
    logic [31:0] dut_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] ent_data;

    function automatic bit is_known(input logic [11:0] a);
        return a inside {CSR_SSTATUS, CSR_STVEC, CSR_MSTATUS, CSR_MTVEC, CSR_SCAPS, CSR_SRANDOM};
    endfunction

    assign csr_rval    = (csr_addr == CSR_SRANDOM) ? ent_data : dut_mem[csr_addr];
    assign csr_illegal = !is_known(csr_addr);

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) dut_mem[addrs[i]] <= ref_mem[addrs[i]];
        end else if (csr_en && is_known(csr_addr) && csr_addr != CSR_SRANDOM) begin
            case (csr_funct3[1:0])
                2'b01:   dut_mem[csr_addr] <= csr_wval;
                2'b10:   dut_mem[csr_addr] <= dut_mem[csr_addr] | csr_wval;
                2'b11:   dut_mem[csr_addr] <= dut_mem[csr_addr] & ~csr_wval;
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          trap;
        bit          wbv;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] epc;
        logic [31:0] tval;
        int          hs;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] wval;
    } en_t;

    exp_t exp_q[$];
    en_t  en_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_en) begin
                chk("en_exclusive", {29'b0, done, wb_valid, trap_req}, 32'd0);
                if (en_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_csr_en: got addr 0x%0h expected no access (cycle %0d)", csr_addr, cyc);
                end else begin
                    en_t n;
                    n = en_q.pop_front();
                    chk("csr_addr", {20'b0, csr_addr}, {20'b0, n.addr});
                    chk("csr_funct3", {29'b0, csr_funct3}, {29'b0, n.f3});
                    chk("csr_wval", csr_wval, n.wval);
                end
            end
            if (wb_valid || trap_req) begin
                chk("wb_trap_with_done", {30'b0, done, wb_valid & trap_req}, 32'd2);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_latency", cyc - e.hs + 1, e.lat);
                    chk("trap_req", {31'b0, trap_req}, {31'b0, e.trap});
                    chk("wb_valid", {31'b0, wb_valid}, {31'b0, e.wbv});
                    if (e.wbv) begin
                        chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                        chk("wb_data", wb_data, e.data);
                    end
                    if (e.trap) begin
                        chk("trap_cause", trap_cause, 32'd2);
                        chk("trap_epc", trap_epc, e.epc);
                        chk("trap_tval", trap_tval, e.tval);
                    end
                end
            end
        end
    end

    // ---------------- driver + reference model ----------------
    // kmode: 0 none, 1 kill in ISSUE, 2 kill in RESP, 3 kill during entropy wait
    task automatic do_req(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                          input logic [4:0] zimm, input logic [4:0] rd, input logic [31:0] pc,
                          input priv_e priv, input int lowc, input int kmode, input logic [31:0] edata);
        logic [31:0] op;
        bit          wr, ill, do_en, killed;
        exp_t        e;
        en_t         n;
        int          k;

        @(negedge clk);
        k = 0;
        while (!req_ready && k < 64) begin @(negedge clk); k++; end
        if (k == 64) chk("ready_timeout", 0, 1);

        entropy_valid = (lowc == 0);
        ent_data      = edata;
        req_funct3 = f3; req_csr_addr = addr; req_rs1_val = rs1; req_zimm = zimm;
        req_rd = rd; req_pc = pc; cur_priv = priv; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        op  = f3[2] ? {27'b0, zimm} : rs1;
        wr  = (f3[1:0] == 2'b01) || (f3[1:0] != 2'b00 && op != 0);
        ill = (f3[1:0] == 2'b00) || (int'(addr[9:8]) > int'(priv)) || (addr[11:10] == 2'b11 && wr);
        e.hs = cyc; e.lat = 3; e.trap = 0; e.data = '0; do_en = 0;
        e.rd = rd; e.epc = pc; e.tval = {20'b0, addr};
        if (ill) begin
            e.trap = 1;
        end else if (addr == CSR_SRANDOM && lowc > 0) begin
`ifdef CSR_SRANDOM_RETRY_EN
            if (lowc <= int'(W)) begin do_en = 1; e.lat = 3 + lowc; e.data = edata; end
            else begin e.trap = 1; e.lat = 3 + int'(W); end
`else
            e.trap = 1;
`endif
        end else begin
            do_en = 1;
            if (!is_known(addr)) e.trap = 1;
            else if (addr == CSR_SRANDOM) e.data = edata;
            else e.data = ref_mem[addr];
        end
        e.wbv  = !e.trap && rd != 0;
        killed = (kmode == 1) || (kmode == 3);

        if (!killed) begin
            exp_q.push_back(e);
            if (do_en) begin
                n.f3 = f3; n.addr = addr; n.wval = op;
                en_q.push_back(n);
                if (is_known(addr) && addr != CSR_SRANDOM) begin
                    case (f3[1:0])
                        2'b01:   ref_mem[addr] = op;
                        2'b10:   ref_mem[addr] = ref_mem[addr] | op;
                        2'b11:   ref_mem[addr] = ref_mem[addr] & ~op;
                        default: ;
                    endcase
                end
            end
        end

        if (kmode == 1) begin
            kill_i = 1'b1;
            @(posedge clk); #1 kill_i = 1'b0;
            chk("kill_issue_ready", {31'b0, req_ready}, 32'd1);
        end else if (kmode == 2) begin
            @(posedge clk); #1 kill_i = 1'b1;
            @(posedge clk); #1 kill_i = 1'b0;
        end else if (kmode == 3) begin
            repeat (3) @(posedge clk);
            #1 kill_i = 1'b1;
            @(posedge clk); #1 kill_i = 1'b0;
            chk("kill_wait_ready", {31'b0, req_ready}, 32'd1);
        end else if (lowc > 0) begin
            repeat (lowc) @(posedge clk);
            #1 entropy_valid = 1'b1;
        end

        k = 0;
        while (!req_ready && k < 64) begin @(negedge clk); k++; end
        if (k == 64) chk("done_timeout", 0, 1);
        entropy_valid = 1'b1;
    endtask

    function automatic priv_e rand_priv();
        case ($urandom_range(0, 2))
            0:       return PRIV_U;
            1:       return PRIV_S;
            default: return PRIV_M;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_csr_addr = '0;
        req_rs1_val = '0; req_zimm = '0; req_rd = '0; req_pc = '0; cur_priv = PRIV_U;
        kill_i = 1'b0; entropy_valid = 1'b1; ent_data = '0;
        for (int i = 0; i < 8; i++) ref_mem[addrs[i]] = $urandom;
        ref_mem[CSR_SCAPS] = 32'h0000_00F1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_outputs", {28'b0, csr_en, wb_valid, done, trap_req}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_trap_cause", trap_cause, 32'd0);
        rst_n = 1'b1;

        // CSRRW stvec from S
        do_req(3'b001, CSR_STVEC, 32'h8000_0103, 5'd0, 5'd5, 32'h1000, PRIV_S, 0, 0, '0);
        // CSRRS mstatus from S: privilege trap
        do_req(3'b010, CSR_MSTATUS, 32'd0, 5'd0, 5'd7, 32'h1004, PRIV_S, 0, 0, '0);
        // SCAPS: write rejected, read allowed
        do_req(3'b001, CSR_SCAPS, 32'h1234, 5'd0, 5'd3, 32'h1008, PRIV_M, 0, 0, '0);
        do_req(3'b010, CSR_SCAPS, 32'd0, 5'd0, 5'd3, 32'h100C, PRIV_M, 0, 0, '0);
        // SRANDOM with entropy arriving after 5 cycles
        do_req(3'b010, CSR_SRANDOM, 32'd0, 5'd0, 5'd9, 32'h1010, PRIV_S, 5, 0, 32'hA5A5_A5A5);
`ifdef CSR_SRANDOM_RETRY_EN
        // entropy never arrives in time, then a kill mid-wait
        do_req(3'b010, CSR_SRANDOM, 32'd0, 5'd0, 5'd9, 32'h1014, PRIV_S, int'(W) + 4, 0, 32'h1);
        do_req(3'b010, CSR_SRANDOM, 32'd0, 5'd0, 5'd9, 32'h1018, PRIV_S, 100, 3, 32'h2);
`endif
        // unknown address rejected by the CSR file
        do_req(3'b010, 12'h7C0, 32'd0, 5'd0, 5'd4, 32'h101C, PRIV_M, 0, 0, '0);
        // kill in ISSUE and kill in RESP
        do_req(3'b001, CSR_MTVEC, 32'hDEAD_BEEF, 5'd0, 5'd2, 32'h1020, PRIV_M, 0, 1, '0);
        do_req(3'b001, CSR_MTVEC, 32'hCAFE_0001, 5'd0, 5'd2, 32'h1024, PRIV_M, 0, 2, '0);

        // reset asserted while in ISSUE
        @(negedge clk);
        req_funct3 = 3'b001; req_csr_addr = CSR_STVEC; req_rs1_val = 32'h55; req_rd = 5'd1;
        cur_priv = PRIV_M; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_issue_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_issue_en", {31'b0, csr_en}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_en_after_rst", {30'b0, csr_en, done}, 32'd0);
        end

        // randomized requests
        for (int t = 0; t < 150; t++) begin
            logic [11:0] a;
            int          lc, km, r;
            a  = addrs[$urandom_range(0, 7)];
            lc = (a == CSR_SRANDOM) ? int'($urandom_range(0, W + 2)) : 0;
            km = 0;
            if (lc == 0) begin
                r = int'($urandom_range(0, 9));
                km = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            end
            do_req(3'($urandom_range(0, 7)), a,
                   ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                   $urandom, rand_priv(), lc, km, $urandom);
        end

        repeat (4) @(negedge clk);
        chk("resp_queue_empty", exp_q.size(), 0);
        chk("en_queue_empty", en_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
